// File: rtl/gate_truth_checker_pkg.sv
// Shared state encoding and reference truth tables for the gate truth checker.
// Truth-table bit i is the expected gate output for input vector i.
package gate_check_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_SETTLE = SETTLE,
    ST_SAMPLE = SAMPLE,
    ST_DONE   = DONE
  } state_t;

  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] NOR_TT  = 4'b0001;

  function automatic int num_vectors(input int n_inputs);
    return 1 << n_inputs;
  endfunction

endpackage

// File: rtl/gate_truth_checker_if.sv
// Control/result bundle between the checker and its controller/gate under test.
// master drives start and the gate output; slave is the checker itself.
interface gate_truth_checker_if #(
  parameter int N_INPUTS = 2
);
  logic                start;
  logic                y_in;
  logic [N_INPUTS-1:0] vec_out;
  logic                busy;
  logic                done;
  logic                pass;
  logic [N_INPUTS:0]   err_count;
  logic                fail_valid;
  logic [N_INPUTS-1:0] first_fail_vec;

  modport master (
    output start,
    output y_in,
    input  vec_out,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_valid,
    input  first_fail_vec
  );

  modport slave (
    input  start,
    input  y_in,
    output vec_out,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_valid,
    output first_fail_vec
  );
endinterface

// File: rtl/gate_truth_checker_settle_timer.sv
// Loadable down-counter: load sets SETTLE_CYCLES-1, counts to zero, expired_o while zero.
// Load wins over clear; the count rests at zero once expired.
module settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic clear_i,
  output logic expired_o
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps every input vector of a gate in ascending order, holds each for SETTLE_CYCLES,
// samples y_in for one cycle and tallies mismatches against EXPECT_TT.
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int                          N_INPUTS      = 2,
  parameter int                          SETTLE_CYCLES = 2,
  parameter logic [(1<<N_INPUTS)-1:0]    EXPECT_TT     = 4'b1000
) (
  input  logic                 clk,
  input  logic                 rst,
  gate_truth_checker_if.slave  bus
);
  localparam logic [N_INPUTS-1:0] VEC_LAST = {N_INPUTS{1'b1}};
  localparam logic [N_INPUTS:0]   ERR_MAX  = (N_INPUTS+1)'(num_vectors(N_INPUTS));

  state_t              state_q, state_d;
  logic [N_INPUTS-1:0] vec_q, vec_d;
  logic [N_INPUTS:0]   err_q, err_d;
  logic                fail_vld_q, fail_vld_d;
  logic [N_INPUTS-1:0] first_q, first_d;

  logic tmr_load;
  logic tmr_clear;
  logic tmr_expired;
  logic mismatch;

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .clear_i   (tmr_clear),
    .expired_o (tmr_expired)
  );

  // Case inequality so an X/Z from the gate is scored as a failure in simulation.
  assign mismatch = (bus.y_in !== EXPECT_TT[vec_q]);

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    err_d      = err_q;
    fail_vld_d = fail_vld_q;
    first_d    = first_q;
    tmr_load   = 1'b0;
    tmr_clear  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        tmr_clear = 1'b1;
        if (bus.start) begin
          state_d    = ST_SETTLE;
          vec_d      = '0;
          err_d      = '0;
          fail_vld_d = 1'b0;
          first_d    = '0;
          tmr_load   = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (tmr_expired) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
          end
          if (!fail_vld_q) begin
            fail_vld_d = 1'b1;
            first_d    = vec_q;
          end
        end
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
        end else begin
          vec_d    = vec_q + 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      err_q      <= '0;
      fail_vld_q <= 1'b0;
      first_q    <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      err_q      <= err_d;
      fail_vld_q <= fail_vld_d;
      first_q    <= first_d;
    end
  end

  assign bus.vec_out        = vec_q;
  assign bus.busy           = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign bus.done           = (state_q == ST_DONE);
  assign bus.pass           = (state_q == ST_DONE) && (err_q == '0);
  assign bus.err_count      = err_q;
  assign bus.fail_valid     = fail_vld_q;
  assign bus.first_fail_vec = first_q;

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Self-contained stimulus-and-check stage wrapped around a combinational gate under test (AND, OR, XOR, ...).
- Upstream role: drives every input combination onto the gate, in ascending binary order.
- Downstream role: samples the gate output after a settle delay and compares it with a parameterised truth table.
- Reports mismatch count, first failing vector and pass/fail. This replaces hand-written stimulus sequences with a synthesizable, reusable checker.

Parameters:
- N_INPUTS, 2, number of gate inputs; legal range 1..4.
- SETTLE_CYCLES, 2, clock cycles each vector is held before sampling; must be >= 1.
- EXPECT_TT, 4'b1000, expected truth table of width 2**N_INPUTS; bit i is the expected Y for input vector i (default is AND).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- y_in  input  1  output of the gate under test.
- vec_out  output  N_INPUTS  input vector driven to the gate; bit 0 is input A, bit 1 is input B.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start, or reset.
- pass  output  1  high only when done=1 and err_count=0.
- err_count  output  N_INPUTS+1  number of mismatching vectors in the current or last sweep.
- fail_valid  output  1  high once any mismatch has been recorded.
- first_fail_vec  output  N_INPUTS  vector of the first mismatch; valid only when fail_valid=1.

Behaviour:
- Reset:
  - Clock is one clk; reset is asynchronous and active-high.
  - Asserting rst at any time forces state IDLE immediately, without waiting for a clock edge.
  - All outputs go to 0, and the settle counter clears.
  - A sweep interrupted by reset is abandoned. There is no resume.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - busy=0, done=0, vec_out=0.
  - start=1 at an edge: clear err_count, fail_valid and first_fail_vec; set vec_out=0 and settle counter=0; go to SETTLE. busy=1 from that edge.
- SETTLE:
  - vec_out is held stable.
  - The counter increments each edge.
  - When the counter reaches SETTLE_CYCLES-1, go to SAMPLE on the next edge.
- SAMPLE (exactly one cycle):
  - y_in is compared against EXPECT_TT[vec_out] at the edge leaving SAMPLE.
  - On mismatch: err_count increments, saturating at 2**N_INPUTS.
  - On the first mismatch only: fail_valid=1 and first_fail_vec=vec_out.
  - If vec_out == 2**N_INPUTS-1: go to DONE, with busy=0 and done=1.
  - Otherwise: vec_out increments, the counter clears, and the state returns to SETTLE.
- DONE:
  - vec_out holds the last vector; all results are held.
  - pass = (err_count==0).
  - start=1 restarts exactly as from IDLE, clearing the results in the same edge.
- Latency: a full sweep takes 2**N_INPUTS * (SETTLE_CYCLES+1) cycles from the start edge to the edge at which done rises. With the defaults this is 4*3 = 12 cycles.
- start is ignored while busy=1; there is no queueing.
- y_in is sampled only in SAMPLE; glitches during SETTLE are don't-care.
- vec_out changes only on the SAMPLE→SETTLE edge or the start edge. It never changes mid-settle.
- An X or Z on y_in counts as a mismatch; the bench must not rely on this in synthesis.

Decomposition:
- Package gate_check_pkg:
  - State encoding constants: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3.
  - Truth-table constants: AND_TT=4'b1000, OR_TT=4'b1110, XOR_TT=4'b0110, NAND_TT=4'b0111, NOR_TT=4'b0001.
- One natural sub-module: settle_timer.
  - Loadable down-counter with clear and an expired flag, parameterised by SETTLE_CYCLES.
  - Instantiated once and driven by the FSM.

Test Plan:
- Correct AND gate, defaults, start pulsed 1 cycle → vec_out steps 00,01,10,11, each held 3 cycles; done rises 12 cycles after the start edge; pass=1, err_count=0, fail_valid=0.
- y_in tied to 0, EXPECT_TT=AND_TT → done; err_count=1, fail_valid=1, first_fail_vec=2'b11, pass=0.
- y_in tied to 1, EXPECT_TT=AND_TT → err_count=3, first_fail_vec=2'b00, pass=0.
- OR gate with EXPECT_TT=AND_TT → err_count=2, first_fail_vec=2'b01.
- rst asserted between clock edges while vec_out=2'b10 → all outputs 0 and state IDLE before the next edge. A following start produces a full clean 12-cycle sweep.
- start held high throughout the sweep → ignored while busy, so the sweep is not restarted. In DONE, start re-launches the sweep: err_count clears on that edge and vec_out returns to 00.
